// File: rtl/reg_file_param.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_param
// Purpose  : Parametrised register file, two registered read ports, one write
//            port, synchronised switch field and two debug taps.
//            Optional write-to-read forwarding: define REGFILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_param #(
    parameter int WIDTH    = 32,
    parameter int AW       = 5,
    parameter int IN_IDX   = 1,
    parameter int IN_W     = 3,
    parameter int TAP0_IDX = 2,
    parameter int TAP1_IDX = 3,
    parameter int ZERO_R0  = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             RegW,
    input  logic [AW-1:0]    DR,
    input  logic [WIDTH-1:0] Reg_In,
    input  logic             RdEn,
    input  logic [AW-1:0]    SR1,
    input  logic [AW-1:0]    SR2,
    input  logic [IN_W-1:0]  iSW,
    output logic [WIDTH-1:0] ReadReg1,
    output logic [WIDTH-1:0] ReadReg2,
    output logic [WIDTH-1:0] oTap0,
    output logic [WIDTH-1:0] oTap1
);

    localparam int          DEPTH     = 2 ** AW;
    localparam logic [AW-1:0] IN_ADDR = AW'(IN_IDX);

    logic [IN_W-1:0]  sync_s1;
    logic [IN_W-1:0]  sync_s2;
    logic [WIDTH-1:0] reg_q [DEPTH];
    logic [WIDTH-1:0] rd_val1;
    logic [WIDTH-1:0] rd_val2;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
        end else begin
            sync_s1 <= iSW;
            sync_s2 <= sync_s1;
        end
    end

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_reg
            if ((ZERO_R0 != 0) && (i == 0)) begin : g_zero
                assign reg_q[i] = '0;
            end else if (i == IN_IDX) begin : g_in_port
                // Low field tracks the switches every edge; only the upper field is writable.
                logic [WIDTH-1:IN_W] hi_q;
                logic [IN_W-1:0]     lo_q;

                always_ff @(posedge CLK or negedge RST_N) begin
                    if (!RST_N) begin
                        hi_q <= '0;
                        lo_q <= '0;
                    end else begin
                        lo_q <= sync_s2;
                        if (RegW && (DR == AW'(i))) begin
                            hi_q <= Reg_In[WIDTH-1:IN_W];
                        end
                    end
                end

                assign reg_q[i] = {hi_q, lo_q};
            end else begin : g_plain
                logic [WIDTH-1:0] q;

                always_ff @(posedge CLK or negedge RST_N) begin
                    if (!RST_N) begin
                        q <= '0;
                    end else if (RegW && (DR == AW'(i))) begin
                        q <= Reg_In;
                    end
                end

                assign reg_q[i] = q;
            end
        end
    endgenerate

`ifdef REGFILE_BYPASS_EN
    logic             wr_live;
    logic [WIDTH-1:0] wr_data;

    always_comb begin
        wr_live = RegW && !((ZERO_R0 != 0) && (DR == '0));
        wr_data = (DR == IN_ADDR) ? {Reg_In[WIDTH-1:IN_W], sync_s2} : Reg_In;
    end

    always_comb begin
        rd_val1 = reg_q[SR1];
        rd_val2 = reg_q[SR2];
        if (wr_live && (SR1 == DR)) rd_val1 = wr_data;
        if (wr_live && (SR2 == DR)) rd_val2 = wr_data;
        if ((ZERO_R0 != 0) && (SR1 == '0)) rd_val1 = '0;
        if ((ZERO_R0 != 0) && (SR2 == '0)) rd_val2 = '0;
    end
`else
    always_comb begin
        rd_val1 = reg_q[SR1];
        rd_val2 = reg_q[SR2];
        if ((ZERO_R0 != 0) && (SR1 == '0)) rd_val1 = '0;
        if ((ZERO_R0 != 0) && (SR2 == '0)) rd_val2 = '0;
    end
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ReadReg1 <= '0;
            ReadReg2 <= '0;
        end else if (RdEn) begin
            ReadReg1 <= rd_val1;
            ReadReg2 <= rd_val2;
        end
    end

    assign oTap0 = reg_q[TAP0_IDX];
    assign oTap1 = reg_q[TAP1_IDX];

endmodule
`default_nettype wire

// File: tb/tb_reg_file_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_param
// Purpose  : Self-checking bench for reg_file_param (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_param;

    localparam int WIDTH = 32;
    localparam int AW    = 5;
    localparam int IN_W  = 3;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             RegW = 1'b0;
    logic [AW-1:0]    DR = '0;
    logic [WIDTH-1:0] Reg_In = '0;
    logic             RdEn = 1'b0;
    logic [AW-1:0]    SR1 = '0;
    logic [AW-1:0]    SR2 = '0;
    logic [IN_W-1:0]  iSW = '0;
    logic [WIDTH-1:0] ReadReg1, ReadReg2, oTap0, oTap1;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    reg_file_param dut (
        .CLK(CLK), .RST_N(RST_N), .RegW(RegW), .DR(DR), .Reg_In(Reg_In),
        .RdEn(RdEn), .SR1(SR1), .SR2(SR2), .iSW(iSW),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .oTap0(oTap0), .oTap1(oTap1)
    );

    always #5 CLK = ~CLK;

    // Reference model: architectural register contents, switch pipeline, read outputs.
    logic [WIDTH-1:0] m_reg [32];
    logic [IN_W-1:0]  m_s1 = '0, m_s2 = '0;
    logic [WIDTH-1:0] m_rd1 = '0, m_rd2 = '0;

    initial for (int i = 0; i < 32; i++) m_reg[i] = '0;

    function automatic logic [WIDTH-1:0] m_read(input logic [AW-1:0] a);
        logic [WIDTH-1:0] v;
        v = (a == 0) ? '0 : m_reg[a];
`ifdef REGFILE_BYPASS_EN
        if (RegW && a == DR && DR != 0)
            v = (DR == 1) ? {Reg_In[WIDTH-1:IN_W], m_s2} : Reg_In;
`endif
        return v;
    endfunction

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 32; i++) m_reg[i] = '0;
            m_s1 = '0; m_s2 = '0; m_rd1 = '0; m_rd2 = '0;
        end else begin
            logic [WIDTH-1:0] n1, n2;
            n1 = m_read(SR1);
            n2 = m_read(SR2);
            if (RdEn) begin m_rd1 = n1; m_rd2 = n2; end
            if (RegW && DR != 0) m_reg[DR] = Reg_In;
            m_reg[1][IN_W-1:0] = m_s2;
            m_s2 = m_s1;
            m_s1 = iSW;
        end
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (checking) begin
            check("model_rd1",  ReadReg1, m_rd1);
            check("model_rd2",  ReadReg2, m_rd2);
            check("model_tap0", oTap0, (m_reg[2]));
            check("model_tap1", oTap1, (m_reg[3]));
        end
    end

    // Apply one cycle of inputs, return at the following falling edge.
    task automatic cyc(input logic w, input logic [AW-1:0] d, input logic [WIDTH-1:0] din,
                       input logic re, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        RegW = w; DR = d; Reg_In = din; RdEn = re; SR1 = a1; SR2 = a2;
        @(negedge CLK);
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        check("reset_rd1", ReadReg1, 32'h0);
        check("reset_tap0", oTap0, 32'h0);
        RST_N = 1'b1;
        checking = 1'b1;

        // Populate then pulse reset between edges.
        cyc(1, 5, 32'hDEADBEEF, 0, 0, 0);
        cyc(1, 2, 32'h0000BEEF, 1, 5, 5);
        cyc(1, 3, 32'h00000F00, 1, 5, 2);
        check("pre_reset_rd1", ReadReg1, 32'hDEADBEEF);
        #2 RST_N = 1'b0;
        #1;
        check("async_rst_rd1", ReadReg1, 32'h0);
        check("async_rst_rd2", ReadReg2, 32'h0);
        check("async_rst_tap0", oTap0, 32'h0);
        check("async_rst_tap1", oTap1, 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        cyc(0, 0, 0, 1, 5, 5);
        check("r5_after_reset", ReadReg1, 32'h0);

        // Write then read, then hold.
        cyc(1, 2, 32'h12345678, 0, 0, 0);
        check("tap0_write", oTap0, 32'h12345678);
        cyc(0, 0, 0, 1, 2, 2);
        check("read_r2", ReadReg1, 32'h12345678);
        cyc(1, 2, 32'h0BADF00D, 0, 2, 2);
        cyc(0, 0, 32'h55555555, 0, 2, 2);
        check("hold_rd1", ReadReg1, 32'h12345678);
        check("tap0_new", oTap0, 32'h0BADF00D);

        // Same-cycle read of the write target.
        cyc(1, 7, 32'h00000011, 0, 0, 0);
        cyc(1, 7, 32'hA5A5A5A5, 1, 7, 7);
`ifdef REGFILE_BYPASS_EN
        check("fwd_rd1", ReadReg1, 32'hA5A5A5A5);
`else
        check("old_rd1", ReadReg1, 32'h00000011);
`endif
        cyc(0, 0, 0, 1, 7, 7);
        check("next_rd1", ReadReg1, 32'hA5A5A5A5);

        // Register zero.
        cyc(1, 0, 32'hFFFFFFFF, 1, 0, 0);
        check("r0_rd1", ReadReg1, 32'h0);
        check("r0_rd2", ReadReg2, 32'h0);
        cyc(0, 0, 0, 1, 0, 0);
        check("r0_after", ReadReg2, 32'h0);

        // Switch field through the synchroniser.
        iSW = 3'b101;
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 1);
        check("sw_not_yet", ReadReg1, 32'h0);
        cyc(0, 0, 0, 1, 1, 1);
        check("sw_field", ReadReg1, 32'h00000005);
        cyc(1, 1, 32'hFFFFFFFA, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 1);
        check("r1_merge", ReadReg1, 32'hFFFFFFFD);

        // Dual port and taps.
        cyc(1, 3, 32'hCAFEF00D, 0, 0, 0);
        check("tap1_write", oTap1, 32'hCAFEF00D);
        cyc(0, 0, 0, 1, 3, 3);
        check("dual_rd1", ReadReg1, 32'hCAFEF00D);
        check("dual_rd2", ReadReg2, 32'hCAFEF00D);

        // Mixed traffic, including writes to r1 while the switches change.
        for (int i = 0; i < 24; i++) begin
            iSW = 3'(i * 3);
            cyc(1'(i % 3 != 2), 5'(i % 8), 32'h01010101 * (i + 1), 1'(i % 4 != 3),
                5'((i + 1) % 8), 5'(i % 8));
        end

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
